// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file and its busy scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef logic [4:0] reg_addr_t;

  // ABI register indices used by decode and the bench.
  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_RA   = 5'd1;
  localparam reg_addr_t REG_SP   = 5'd2;
  localparam reg_addr_t REG_T0   = 5'd5;
  localparam reg_addr_t REG_T1   = 5'd6;
  localparam reg_addr_t REG_T2   = 5'd7;
  localparam reg_addr_t REG_A0   = 5'd10;
  localparam reg_addr_t REG_A1   = 5'd11;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared at writeback or flush,
// with a registered popcount of outstanding reservations.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_addr,
  input  logic             flush,
  output logic             issue_ready,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      pending_cnt
);

  logic [NREGS-1:0] busy_reg, busy_next;
  logic [AW:0]      cnt_reg, cnt_next;

  // Ready looks only at the pre-edge busy bit, so a writeback in the same
  // cycle does not release a WAW stall.
  assign issue_ready = ~busy_reg[issue_addr];

  always_comb begin
    busy_next = busy_reg;
    if (we && waddr != AW'(REG_ZERO))
      busy_next[waddr] = 1'b0;
    // Applied after the writeback clear so a same-register issue wins.
    if (issue_valid && issue_ready && issue_addr != AW'(REG_ZERO))
      busy_next[issue_addr] = 1'b1;
    if (flush)
      busy_next = '0;
    cnt_next = '0;
    for (int i = 0; i < NREGS; i++)
      cnt_next = cnt_next + (AW+1)'(busy_next[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      busy_reg <= busy_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign busy        = busy_reg;
  assign pending_cnt = cnt_reg;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with NRD combinational read ports, one write port and a busy scoreboard.
// Optional write-through forwarding to the read ports: define REGFILE_SB_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_val,
  output logic [NRD-1:0]    rd_busy,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_addr,
  output logic              issue_ready,
  input  logic              flush,
  output logic [AW:0]       pending_cnt,
  input  logic [AW-1:0]     dbg_addr,
  output logic [XLEN-1:0]   dbg_val
);

  logic [XLEN-1:0]  regs_reg [NREGS];
  logic [NREGS-1:0] busy;

  regfile_scoreboard #(.NREGS(NREGS), .AW(AW)) u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .we          (we),
    .waddr       (waddr),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .flush       (flush),
    .issue_ready (issue_ready),
    .busy        (busy),
    .pending_cnt (pending_cnt)
  );

  // x0 is never written, so it holds the reset value of zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs_reg[i] <= '0;
    end else if (we && waddr != AW'(REG_ZERO)) begin
      regs_reg[waddr] <= wdata;
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] addr;
    logic          is_zero;
    assign addr    = rd_addr[gi*AW +: AW];
    assign is_zero = (addr == AW'(REG_ZERO));
`ifdef REGFILE_SB_BYPASS_EN
    logic fwd;
    assign fwd = we && (waddr == addr) && !is_zero;
    assign rd_val[gi*XLEN +: XLEN] = is_zero ? '0 : (fwd ? wdata : regs_reg[addr]);
    assign rd_busy[gi]             = !is_zero && !fwd && busy[addr];
`else
    assign rd_val[gi*XLEN +: XLEN] = is_zero ? '0 : regs_reg[addr];
    assign rd_busy[gi]             = !is_zero && busy[addr];
`endif
  end

  assign dbg_val = regs_reg[dbg_addr];

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios followed by random traffic,
// all compared against an array-based reference model of the register file.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clock = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_val;
  logic [NRD-1:0]      rd_busy;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic                issue_valid;
  logic [AW-1:0]       issue_addr;
  logic                issue_ready;
  logic                flush;
  logic [AW:0]         pending_cnt;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_val;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural contents and the set of reserved registers.
  logic [XLEN-1:0] m_regs [NREGS];
  bit   [NREGS-1:0] m_busy;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clock       (clock),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_val      (rd_val),
    .rd_busy     (rd_busy),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .flush       (flush),
    .pending_cnt (pending_cnt),
    .dbg_addr    (dbg_addr),
    .dbg_val     (dbg_val)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    reset = 0; we = 0; waddr = '0; wdata = '0;
    issue_valid = 0; issue_addr = '0; flush = 0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  function automatic logic [XLEN-1:0] port_val(input int k);
    return rd_val[k*XLEN +: XLEN];
  endfunction

  // Compare every DUT output against what the model says it should be now.
  task automatic check_all(input string ctx);
    for (int k = 0; k < NRD; k++) begin
      int a;
      logic [XLEN-1:0] ev;
      logic eb;
      a  = int'(rd_addr[k*AW +: AW]);
      ev = (a == 0) ? '0 : m_regs[a];
      eb = (a != 0) && m_busy[a];
`ifdef REGFILE_SB_BYPASS_EN
      if (we && int'(waddr) == a && a != 0) begin
        ev = wdata;
        eb = 1'b0;
      end
`endif
      chk($sformatf("%s.rd_val%0d[x%0d]", ctx, k, a), 64'(port_val(k)), 64'(ev));
      chk($sformatf("%s.rd_busy%0d[x%0d]", ctx, k, a), 64'(rd_busy[k]), 64'(eb));
    end
    chk({ctx, ".issue_ready"}, 64'(issue_ready), 64'(!m_busy[issue_addr]));
    chk({ctx, ".pending_cnt"}, 64'(pending_cnt), 64'($countones(m_busy)));
    chk({ctx, ".dbg_val"}, 64'(dbg_val), 64'(m_regs[dbg_addr]));
  endtask

  // Advance one clock; the model applies the inputs that were present at the edge.
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_busy = '0;
    end else begin
      bit accept;
      accept = issue_valid && !m_busy[issue_addr] && issue_addr != 0;
      if (we && waddr != 0) begin
        m_regs[waddr] = wdata;
        m_busy[waddr] = 1'b0;
      end
      if (accept) m_busy[issue_addr] = 1'b1;
      if (flush) m_busy = '0;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_busy = '0;
    set_idle();
    dbg_addr = '0;
    set_rd(0, 0);

    // 1. reset, then every register reads zero and nothing is pending
    reset = 1;
    tick();
    tick();
    reset = 0;
    for (int a = 0; a < NREGS; a++) begin
      set_rd(a, NREGS - 1 - a);
      dbg_addr = AW'(a);
      #1;
      chk($sformatf("reset.zero_x%0d", a), 64'(port_val(0)), 64'(0));
      check_all("reset");
    end
    chk("reset.issue_ready", 64'(issue_ready), 64'(1));

    // 2. write x5, attempt write to x0
    we = 1; waddr = 5; wdata = 32'hDEADBEEF;
    tick();
    waddr = 0; wdata = 32'h1234;
    tick();
    we = 0;
    set_rd(5, 0);
    dbg_addr = 0;
    #1;
    chk("write.x5", 64'(port_val(0)), 64'(32'hDEADBEEF));
    chk("write.x0", 64'(port_val(1)), 64'(0));
    chk("write.dbg_x0", 64'(dbg_val), 64'(0));
    check_all("write");

    // 3. WAW stall on x7, released by writeback
    issue_valid = 1; issue_addr = 7;
    set_rd(7, 5);
    #1;
    check_all("issue7a");
    tick();
    #1;
    chk("issue7.second_ready", 64'(issue_ready), 64'(0));
    chk("issue7.pending", 64'(pending_cnt), 64'(1));
    check_all("issue7b");
    tick();
    issue_valid = 1; we = 1; waddr = 7; wdata = 32'h55;
    #1;
    chk("issue7.ready_during_wb", 64'(issue_ready), 64'(0));
    check_all("wb7");
    tick();
    set_idle();
    #1;
    chk("wb7.pending", 64'(pending_cnt), 64'(0));
    chk("wb7.busy", 64'(rd_busy[0]), 64'(0));
    check_all("wb7b");

    // 4. read x10 while writing it
    we = 1; waddr = 10; wdata = 32'h11111111;
    tick();
    wdata = 32'hA5A5A5A5;
    set_rd(10, 10);
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    chk("fwd.same_cycle", 64'(port_val(0)), 64'(32'hA5A5A5A5));
`else
    chk("fwd.same_cycle", 64'(port_val(0)), 64'(32'h11111111));
`endif
    check_all("fwd");
    tick();
    we = 0;
    #1;
    chk("fwd.next_cycle", 64'(port_val(0)), 64'(32'hA5A5A5A5));

    // 5. three reservations, then flush discards a same-cycle issue
    for (int r = 1; r <= 3; r++) begin
      issue_valid = 1; issue_addr = AW'(r);
      #1;
      check_all($sformatf("iss%0d", r));
      tick();
    end
    issue_valid = 0;
    #1;
    chk("flush.pre_pending", 64'(pending_cnt), 64'(3));
    issue_valid = 1; issue_addr = 4; flush = 1;
    #1;
    check_all("flush");
    tick();
    set_idle();
    issue_addr = 4;
    set_rd(4, 1);
    #1;
    chk("flush.pending", 64'(pending_cnt), 64'(0));
    chk("flush.x4_busy", 64'(rd_busy[0]), 64'(0));
    chk("flush.x4_ready", 64'(issue_ready), 64'(1));

    // 6. issue and write x11 together, then reset mid-sequence
    issue_valid = 1; issue_addr = 11; we = 1; waddr = 11; wdata = 32'hCAFE;
    tick();
    set_idle();
    set_rd(11, 10);
    dbg_addr = 11;
    #1;
    chk("setwins.busy", 64'(rd_busy[0]), 64'(1));
    chk("setwins.data", 64'(port_val(0)), 64'(32'hCAFE));
    chk("setwins.pending", 64'(pending_cnt), 64'(1));
    check_all("setwins");
    reset = 1; we = 1; waddr = 12; wdata = 32'h77; issue_valid = 1; issue_addr = 13;
    tick();
    set_idle();
    #1;
    chk("midreset.pending", 64'(pending_cnt), 64'(0));
    chk("midreset.x11", 64'(port_val(0)), 64'(0));
    chk("midreset.dbg", 64'(dbg_val), 64'(0));
    check_all("midreset");

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 99) == 0);
      flush       = ($urandom_range(0, 29) == 0);
      we          = $urandom_range(0, 1);
      waddr       = AW'($urandom_range(0, NREGS - 1));
      wdata       = $urandom;
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_addr  = AW'($urandom_range(0, NREGS - 1));
      dbg_addr    = AW'($urandom_range(0, NREGS - 1));
      set_rd($urandom_range(0, 3) == 0 ? int'(waddr) : $urandom_range(0, NREGS - 1),
             $urandom_range(0, NREGS - 1));
      #1;
      check_all("rand");
      chk("rand.pending_max", 64'(pending_cnt <= NREGS - 1), 64'(1));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
